// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the PC register, issues single-outstanding imem reads and
// buffers {pc, instr} pairs for decode. Optional perf counters under `FETCH_PERF_EN`.
module instr_fetch_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    output logic [AW-1:0] pc_next,
    output logic          pc_enable,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic          imem_valid,
    input  logic [DW-1:0] imem_rdata,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StSquash} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            outstanding_q, outstanding_d;
    logic [AW-1:0]   req_pc_q, req_pc_d;
    logic [AW-1:0]   pc_buf_q    [DEPTH];
    logic [DW-1:0]   instr_buf_q [DEPTH];

    logic            space, accept, push, pop, flush;
    logic [CntW-1:0] occupancy;

    // A slot is reserved at request acceptance, so push can never hit a full buffer.
    assign occupancy = count_q + CntW'(outstanding_q);
    assign space     = occupancy < CntW'(DEPTH);
    assign flush     = redirect_valid && (state_q != StIdle);
    assign imem_addr = pc;

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        req_pc_d      = req_pc_q;
        imem_req      = 1'b0;
        pc_enable     = 1'b0;
        pc_next       = '0;
        accept        = 1'b0;
        push          = 1'b0;
        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                imem_req = space;
                accept   = space && imem_ready;
                if (accept) begin
                    req_pc_d      = pc;
                    outstanding_d = 1'b1;
                    pc_enable     = 1'b1;
                    pc_next       = pc + AW'(4);
                    state_d       = StWait;
                end
                // Without an accepted request SQUASH has nothing to drain and exits at once.
                if (redirect_valid) state_d = StSquash;
            end
            StWait: begin
                if (imem_valid) begin
                    outstanding_d = 1'b0;
                    push          = !redirect_valid;
                    state_d       = StReq;
                end else if (redirect_valid) begin
                    state_d = StSquash;
                end
            end
            StSquash: begin
                if (imem_valid || !outstanding_q) begin
                    outstanding_d = 1'b0;
                    state_d       = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            pc_enable = 1'b1;
            pc_next   = redirect_pc;
        end
    end

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready && !flush;
    assign instr       = instr_valid ? instr_buf_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? pc_buf_q[rd_ptr_q] : '0;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= 1'b0;
            req_pc_q      <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            req_pc_q      <= req_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf_q[wr_ptr_q]    <= req_pc_q;
            instr_buf_q[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;
    logic        stall;

    assign stall        = (state_q == StReq) && (!space || (imem_req && !imem_ready));
    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push)  perf_fetched_q <= perf_fetched_q + 32'd1;
            if (stall) perf_stall_q   <= perf_stall_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC register and variable-latency memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [31:0] pc_next;
    logic        pc_enable;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    int checks = 0;
    int errors = 0;
    int lat_cfg = 1;
    int pe_cnt = 0;
    int pe_base = 0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_load_val = 32'h0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pc_next        (pc_next),
        .pc_enable      (pc_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'hBEEF} ^ a;
    endfunction

    // PC register driven by the DUT, with a bench-side preload.
    always @(posedge clk) begin
        if (pc_load) pc <= pc_load_val;
        else if (pc_enable) pc <= pc_next;
    end

    // Memory: lat_cfg cycles from acceptance edge to the edge that samples imem_valid.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend       <= 1'b0;
            imem_valid <= 1'b0;
        end else begin
            imem_valid <= 1'b0;
            if (imem_req && imem_ready) begin
                if (lat_cfg <= 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem_word(imem_addr);
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= imem_addr;
                    pend_cnt  <= lat_cfg - 1;
                end
            end else if (pend) begin
                if (pend_cnt <= 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem_word(pend_addr);
                    pend       <= 1'b0;
                end else begin
                    pend_cnt <= pend_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) if (reset && pc_enable) pe_cnt <= pe_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic load, input logic [31:0] val);
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        pc_load        = load;
        pc_load_val    = val;
        @(negedge clk);
        pc_load = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_instr(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (instr_valid) break;
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        pc_load     = 1'b1;
        pc_load_val = 32'h0;
        @(negedge clk);
        pc_load = 1'b0;
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_pc_enable", 32'(pc_enable), 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_pc_next", pc_next, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'h0);
        check("rst_perf_stall", perf_stall, 32'h0);
`endif
        @(negedge clk);
        reset   = 1'b1;
        pe_base = pe_cnt;

        // Straight-line fetch from 0
        for (int k = 0; k < 4; k++) begin
            wait_instr(10);
            check("t1_valid", 32'(instr_valid), 32'h1);
            check("t1_instr_pc", instr_pc, 32'(4 * k));
            check("t1_instr", instr, mem_word(32'(4 * k)));
        end
        check("t1_pc_enable_pulses", 32'(pe_cnt - pe_base), 32'd4);
        check("t1_pc", pc, 32'd16);

        // Decode stall fills the buffer
        instr_ready = 1'b0;
        do_reset(1'b1, 32'h0);
        repeat (8) @(negedge clk);
        check("t2_valid", 32'(instr_valid), 32'h1);
        check("t2_req_held", 32'(imem_req), 32'h0);
        check("t2_pc_frozen", pc, 32'd8);
        check("t2_pc_enable", 32'(pc_enable), 32'h0);
        check("t2_head_pc", instr_pc, 32'h0);
        check("t2_head_instr", instr, mem_word(32'h0));
`ifdef FETCH_PERF_EN
        check("t2_perf_fetched", perf_fetched, 32'd2);
        check("t2_perf_stall", perf_stall, 32'd3);
`endif
        instr_ready = 1'b1;
        @(negedge clk);
        check("t2_second_valid", 32'(instr_valid), 32'h1);
        check("t2_second_pc", instr_pc, 32'd4);
        check("t2_second_instr", instr, mem_word(32'd4));
        check("t2_req_resumed", 32'(imem_req), 32'h1);
        @(negedge clk);
        check("t2_drained", 32'(instr_valid), 32'h0);

        // Redirect during WAIT with 3-cycle latency
        lat_cfg = 3;
        do_reset(1'b1, 32'h40);
        @(negedge clk);
        check("t3_req", 32'(imem_req), 32'h1);
        check("t3_addr", imem_addr, 32'h40);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("t3_redir_en", 32'(pc_enable), 32'h1);
        check("t3_redir_next", pc_next, 32'h100);
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t3_squash_req", 32'(imem_req), 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("t3_new_req", 32'(imem_req), 32'h1);
        check("t3_new_addr", imem_addr, 32'h100);
        check("t3_empty", 32'(instr_valid), 32'h0);
        wait_instr(20);
        check("t3_valid", 32'(instr_valid), 32'h1);
        check("t3_instr_pc", instr_pc, 32'h100);
        check("t3_instr", instr, mem_word(32'h100));

        // Redirect coinciding with imem_valid
        lat_cfg = 1;
        do_reset(1'b1, 32'h0);
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("t4_dropped", 32'(instr_valid), 32'h0);
        check("t4_req", 32'(imem_req), 32'h1);
        check("t4_addr", imem_addr, 32'h200);
        check("t4_pc_enable", 32'(pc_enable), 32'h1);
        check("t4_pc_next", pc_next, 32'h204);
        wait_instr(10);
        check("t4_valid", 32'(instr_valid), 32'h1);
        check("t4_instr_pc", instr_pc, 32'h200);

        // PC wraparound
        do_reset(1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        check("t5_pc_enable", 32'(pc_enable), 32'h1);
        check("t5_pc_next", pc_next, 32'h0);
        check("t5_addr", imem_addr, 32'hFFFF_FFFC);
        wait_instr(10);
        check("t5_instr_pc", instr_pc, 32'hFFFF_FFFC);
        check("t5_next_addr", imem_addr, 32'h0);

        // Asynchronous reset while WAIT with a buffered entry
        instr_ready = 1'b0;
        do_reset(1'b1, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        lat_cfg = 3;
        @(negedge clk);
        check("t6_pre_valid", 32'(instr_valid), 32'h1);
        reset = 1'b0;
        #1;
        check("t6_instr_valid", 32'(instr_valid), 32'h0);
        check("t6_instr", instr, 32'h0);
        check("t6_instr_pc", instr_pc, 32'h0);
        check("t6_imem_req", 32'(imem_req), 32'h0);
        check("t6_pc_enable", 32'(pc_enable), 32'h0);
        check("t6_pc_next", pc_next, 32'h0);
`ifdef FETCH_PERF_EN
        check("t6_perf_fetched", perf_fetched, 32'h0);
        check("t6_perf_stall", perf_stall, 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_req", 32'(imem_req), 32'h1);
        check("t6_addr", imem_addr, 32'd8);
        check("t6_empty", 32'(instr_valid), 32'h0);
        instr_ready = 1'b1;
        wait_instr(10);
        check("t6_valid", 32'(instr_valid), 32'h1);
        check("t6_first_pc", instr_pc, 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
